// File: rtl/demux12_ctrl_pkg.sv
// demux12_ctrl shared definitions.
// State encoding and data path geometry.
package demux12_ctrl_pkg;

  localparam int BW          = 10;
  localparam int DEST_BIT    = 8;
  localparam int CNT_W       = 8;
  localparam int STALL_LIMIT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } state_t;

endpackage

// File: rtl/demux12_ctrl_if.sv
// demux12_ctrl bus: upstream FIFO, pauses,
// demux drive and status.
interface demux12_ctrl_if #(
  parameter int BW    = 10,
  parameter int CNT_W = 8
);

  logic             enable;
  logic             fifo_empty;
  logic [BW-1:0]    data_in;
  logic             pause_0;
  logic             pause_1;
  logic             pop;
  logic [BW-1:0]    data_out;
  logic             valid_out;
  logic             select;
  logic [CNT_W-1:0] count_0;
  logic [CNT_W-1:0] count_1;
  logic             stall_timeout;
  logic             idle;

  modport master (
    input  enable, fifo_empty, data_in,
    input  pause_0, pause_1,
    output pop, data_out, valid_out, select,
    output count_0, count_1,
    output stall_timeout, idle
  );

  modport slave (
    output enable, fifo_empty, data_in,
    output pause_0, pause_1,
    input  pop, data_out, valid_out, select,
    input  count_0, count_1,
    input  stall_timeout, idle
  );

endinterface

// File: rtl/demux12_ctrl_stall_cnt.sv
// Saturating stall counter with clear and a
// registered limit flag.
module demux12_ctrl_stall_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic timeout
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_nxt;

  // Next count: clear wins, then saturating step
  always_comb begin
    cnt_nxt = cnt_q;
    if (clr)
      cnt_nxt = '0;
    else if (inc && cnt_q != LIM)
      cnt_nxt = cnt_q + 1'b1;
  end

  // Count and flag move on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      timeout <= 1'b0;
    end else begin
      cnt_q   <= cnt_nxt;
      timeout <= (cnt_nxt == LIM);
    end
  end

endmodule

// File: rtl/demux12_ctrl.sv
// FWFT-to-demux scheduler: in-order forwarding
// with per-destination pause and stall watch.
module demux12_ctrl #(
  parameter int BW          = demux12_ctrl_pkg::BW,
  parameter int DEST_BIT    = demux12_ctrl_pkg::DEST_BIT,
  parameter int CNT_W       = demux12_ctrl_pkg::CNT_W,
  parameter int STALL_LIMIT = demux12_ctrl_pkg::STALL_LIMIT
) (
  input logic            clk,
  input logic            reset,
  demux12_ctrl_if.master bus
);

  import demux12_ctrl_pkg::*;

  state_t           state_q;
  state_t           state_nxt;
  logic             dest;
  logic             blocked;
  logic             pop;
  logic             stay_stall;
  logic             timeout;
  logic [BW-1:0]    data_q;
  logic             sel_q;
  logic             vld_q;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  assign dest    = bus.data_in[DEST_BIT];
  assign blocked = dest ? bus.pause_1
                        : bus.pause_0;

  // Next state and the combinational pop
  always_comb begin
    state_nxt = state_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.enable && !bus.fifo_empty)
          state_nxt = ACTIVE;
      end
      ACTIVE: begin
        pop = !bus.fifo_empty && !blocked;
        if (!bus.enable)
          state_nxt = IDLE;
        else if (!bus.fifo_empty && blocked)
          state_nxt = STALL;
        else if (bus.fifo_empty)
          state_nxt = IDLE;
      end
      STALL: begin
        if (!bus.enable)
          state_nxt = IDLE;
        else if (!blocked)
          state_nxt = ACTIVE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, demux drive and word counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= 1'b0;
      vld_q   <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_nxt;
      vld_q   <= pop;
      if (pop) begin
        data_q <= bus.data_in;
        sel_q  <= dest;
        if (dest)
          cnt1_q <= cnt1_q + 1'b1;
        else
          cnt0_q <= cnt0_q + 1'b1;
      end
    end
  end

  assign stay_stall = (state_q == STALL) &&
                      (state_nxt == STALL);

  demux12_ctrl_stall_cnt #(
    .LIMIT (STALL_LIMIT)
  ) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (!stay_stall),
    .inc     (stay_stall),
    .timeout (timeout)
  );

  assign bus.pop           = pop;
  assign bus.data_out      = data_q;
  assign bus.valid_out     = vld_q;
  assign bus.select        = sel_q;
  assign bus.count_0       = cnt0_q;
  assign bus.count_1       = cnt1_q;
  assign bus.stall_timeout = timeout;
  assign bus.idle          = (state_q == IDLE);

endmodule

// File: tb/tb_demux12_ctrl.sv
// demux12_ctrl bench: FIFO model, scoreboard
// monitor and directed/random stimulus.
module tb_demux12_ctrl;

  localparam int BW    = 10;
  localparam int CNT_W = 8;
  localparam int DB    = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  demux12_ctrl_if #(
    .BW    (BW),
    .CNT_W (CNT_W)
  ) bus ();

  demux12_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] fifo_q[$];
  logic [BW-1:0] exp_q[$];
  logic          pop_s = 1'b0;
  int            m_c0  = 0;
  int            m_c1  = 0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h",
               name, got, exp);
    end
  endtask

  task automatic refresh();
    if (!reset) fifo_q.delete();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.data_in = bus.fifo_empty ? '0
                                 : fifo_q[0];
  endtask

  // Upstream FWFT FIFO model
  initial begin
    logic          p;
    logic [BW-1:0] h;
    refresh();
    forever begin
      @(posedge clk);
      p = bus.pop;
      if (reset && p) begin
        chk("pop_nonempty", fifo_q.size() != 0, 1);
        if (fifo_q.size() != 0) begin
          h = fifo_q[0];
          chk("pop_unpaused",
              h[DB] ? bus.pause_1 : bus.pause_0, 0);
        end
      end
      pop_s = p;
      #1;
      if (p && fifo_q.size() != 0)
        void'(fifo_q.pop_front());
      refresh();
      @(negedge clk);
      #1;
      refresh();
    end
  end

  // Scoreboard monitor
  initial begin
    logic [BW-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_q.delete();
        m_c0 = 0;
        m_c1 = 0;
      end else begin
        chk("valid_latency", bus.valid_out, pop_s);
        if (bus.valid_out) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("data_out", bus.data_out, e);
            chk("select", bus.select, e[DB]);
            if (e[DB]) m_c1 = (m_c1 + 1) % 256;
            else       m_c0 = (m_c0 + 1) % 256;
          end
        end
        chk("count_0", bus.count_0, m_c0);
        chk("count_1", bus.count_1, m_c1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [BW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  function automatic logic [BW-1:0] rword(
      input logic d);
    logic [BW-1:0] w;
    w = BW'($urandom);
    w[DB] = d;
    return w;
  endfunction

  task automatic drain(input int maxc);
    int n = 0;
    while ((fifo_q.size() != 0 ||
            exp_q.size() != 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left",
        fifo_q.size() + exp_q.size(), 0);
    tick(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Stimulus
  initial begin
    int c0;
    bus.enable  = 1'b0;
    bus.pause_0 = 1'b0;
    bus.pause_1 = 1'b0;
    #1;
    chk("rst_idle", bus.idle, 1);
    chk("rst_pop", bus.pop, 0);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_cnt0", bus.count_0, 0);
    chk("rst_to", bus.stall_timeout, 0);
    @(negedge clk);
    #2 reset = 1'b1;

    // Two words, one per destination
    @(negedge clk);
    bus.enable = 1'b1;
    load(10'h0AA);
    load(10'h155);
    drain(20);
    chk("t1_idle", bus.idle, 1);
    chk("t1_c0", bus.count_0, 1);
    chk("t1_c1", bus.count_1, 1);

    // Blocked head and stall timeout
    bus.pause_1 = 1'b1;
    load(10'h100);
    tick(2);
    tick(15);
    chk("t2_to_early", bus.stall_timeout, 0);
    chk("t2_pop_blk", bus.pop, 0);
    tick(1);
    chk("t2_to_set", bus.stall_timeout, 1);
    chk("t2_pop_blk2", bus.pop, 0);
    bus.pause_1 = 1'b0;
    tick(1);
    chk("t2_to_clr", bus.stall_timeout, 0);
    chk("t2_pop_go", bus.pop, 1);
    drain(20);
    chk("t2_c1", bus.count_1, 2);

    // Pause on the other destination only
    bus.pause_1 = 1'b1;
    for (int i = 0; i < 3; i++) load(rword(1'b0));
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("t3_no_to", bus.stall_timeout, 0);
    end
    drain(20);
    chk("t3_c0", bus.count_0, 4);

    // Async reset while stalled
    load(rword(1'b1));
    tick(6);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("t5_idle", bus.idle, 1);
    chk("t5_pop", bus.pop, 0);
    chk("t5_valid", bus.valid_out, 0);
    chk("t5_data", bus.data_out, 0);
    chk("t5_sel", bus.select, 0);
    chk("t5_c0", bus.count_0, 0);
    chk("t5_c1", bus.count_1, 0);
    chk("t5_to", bus.stall_timeout, 0);
    bus.enable  = 1'b0;
    bus.pause_1 = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    load(10'h0AB);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("t5_hold_pop", bus.pop, 0);
      chk("t5_hold_idle", bus.idle, 1);
    end
    bus.enable = 1'b1;
    drain(20);

    // Long stream wraps count_0
    c0 = m_c0;
    for (int i = 0; i < 260; i++)
      load(rword(1'b0));
    drain(300);
    chk("t4_wrap", bus.count_0, (c0 + 260) % 256);

    // enable drop while active
    for (int i = 0; i < 4; i++)
      load(rword(1'b0));
    tick(1);
    chk("t6_pop_on", bus.pop, 1);
    bus.enable = 1'b0;
    #1;
    chk("t6_final_pop", bus.pop, 1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("t6_off_pop", bus.pop, 0);
      chk("t6_off_idle", bus.idle, 1);
    end
    chk("t6_left", exp_q.size(), 3);
    bus.enable = 1'b1;
    drain(20);

    // Random mix of words and pauses
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if ($urandom_range(0, 1) == 0)
        load(rword(1'($urandom)));
      bus.pause_0 = ($urandom_range(0, 3) == 0);
      bus.pause_1 = ($urandom_range(0, 3) == 0);
    end
    tick(1);
    bus.pause_0 = 1'b0;
    bus.pause_1 = 1'b0;
    drain(400);
    chk("end_idle", bus.idle, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux12_ctrl.md
Name: demux12_ctrl

Overview:
- Scheduler for the 1x2 class/destination demux in the PCIe switching path.
- Reads words from an upstream first-word-fall-through (FWFT) FIFO and picks the demux output from the word's destination bit.
- Throttles against per-destination pause (almost-full) flags from the two downstream FIFOs.
- Drives the demux data/valid/select inputs, keeps per-destination word counts, and flags head-of-line stalls that exceed a limit.

Parameters:
- BW, 10, word width (matches the demux data path).
- DEST_BIT, 8, bit index of data_in that selects the destination (0 -> out0, 1 -> out1).
- CNT_W, 8, width of the per-destination word counters.
- STALL_LIMIT, 16, consecutive stall cycles before stall_timeout asserts.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- enable  in  1  1 = scheduling allowed; 0 = finish current cycle, then IDLE.
- fifo_empty  in  1  upstream FIFO empty.
- data_in  in  BW  upstream FIFO head word; valid when fifo_empty=0.
- pause_0  in  1  downstream FIFO 0 almost-full.
- pause_1  in  1  downstream FIFO 1 almost-full.
- pop  out  1  upstream FIFO read strobe (combinational).
- data_out  out  BW  word to demux "in" (registered).
- valid_out  out  1  to demux valid_in (registered).
- select  out  1  to demux select (registered).
- count_0  out  CNT_W  words sent to destination 0 (wraps).
- count_1  out  CNT_W  words sent to destination 1 (wraps).
- stall_timeout  out  1  head blocked for >= STALL_LIMIT cycles.
- idle  out  1  FSM in IDLE.

Behaviour:
- Reset (reset=0, async):
  - data_out=0, valid_out=0, select=0, count_0=0, count_1=0, stall_timeout=0.
  - Stall counter=0, state=IDLE; idle=1 and pop=0 during reset.
- Internal signals:
  - dest = data_in[DEST_BIT].
  - blocked = (dest ? pause_1 : pause_0).
- pop = (state==ACTIVE) && !fifo_empty && !blocked.
  - Combinational; at most one word per cycle.
- Latency:
  - If pop=1 in cycle N, then at the edge closing cycle N: data_out<=data_in, select<=dest, valid_out<=1.
  - The matching count increments at that same edge.
  - The demux therefore sees the word in cycle N+1 and registers it at edge N+1.
- When pop=0: valid_out<=0; data_out and select hold their last values.
- FSM states: IDLE, ACTIVE, STALL.
  - IDLE:
    - pop=0, idle=1.
    - Go to ACTIVE when enable=1 && fifo_empty=0.
  - ACTIVE:
    - Forward as above.
    - If enable=0, go to IDLE next cycle; pop is still allowed this cycle.
    - Else if !fifo_empty && blocked, go to STALL.
    - Else if fifo_empty, go to IDLE.
  - STALL:
    - pop=0.
    - Stall counter increments each cycle, saturating at STALL_LIMIT.
    - stall_timeout is registered: it asserts on the edge where the counter reaches STALL_LIMIT.
    - Exit to ACTIVE when blocked drops. Stall counter clears; stall_timeout clears on that same edge.
    - Exit to IDLE when enable=0 (counter cleared).
    - There is no reordering: a blocked head blocks the other destination too (strict in-order).
- Destination and pause conditions:
  - Both pauses high: stall regardless of dest.
  - Pause on the non-head destination only: no effect.
  - pause rising in the same cycle as a valid head: no pop that cycle.
- Counters wrap modulo 2^CNT_W; overflow is not flagged.
- fifo_empty rising while ACTIVE: no pop, valid_out<=0, go to IDLE next edge.
- Reset mid-packet or mid-stall: everything clears immediately. Any word already popped but not yet registered is dropped (the upstream FIFO has already advanced).
- Unused data_in bits are passed through unchanged.

Decomposition:
- Shared package: FSM state encoding constants (IDLE=2'd0, ACTIVE=2'd1, STALL=2'd2), BW, DEST_BIT.
- One natural sub-module: demux12_ctrl_stall_cnt, a saturating counter with clear and a limit compare. Counters and FSM stay in the top.
- The top-level switch instantiates demux12_ctrl feeding demux12.

Test Plan:
1. Reset, then enable=1; FIFO holds 0x0AA (bit8=0) and 0x155 (bit8=1); no pauses.
   - pop high 2 cycles.
   - Cycle after the first pop: data_out=0x0AA, select=0, valid_out=1.
   - Cycle after the second pop: data_out=0x155, select=1, valid_out=1.
   - Then count_0=1, count_1=1, idle=1 after the FIFO empties.
2. Head 0x100 (dest 1) with pause_1=1.
   - pop=0; after 16 cycles stall_timeout=1.
   - Drop pause_1: pop=1 next cycle, stall_timeout=0, count_1 increments.
3. Head dest 0, pause_1=1, pause_0=0 -> forwarded with no stall; stall_timeout stays 0.
4. Stream 260 dest-0 words.
   - count_0 wraps to 4.
   - valid_out high on every cycle after pop.
5. Assert reset=0 asynchronously (between clock edges) while in STALL with count_0=5.
   - All outputs 0 immediately, idle=1.
   - After release, no pop until enable=1 && fifo_empty=0.
6. enable=0 while ACTIVE with the FIFO non-empty.
   - One final pop completes; FSM returns to IDLE; pop stays 0 until enable returns to 1.
